dmem_responder: RTL and testbench

Data-side memory responder for the pipelined MIPS core. It is the slave end of the core's M-stage SRAM-style data interface (memread/memwrite, byte select, address, write data). It serves each request from an internal byte-enabled word RAM after a programmable number of wait states, asserting a stall back to the core until read data is valid or the write is committed. It sits between the core's data port and on-chip data RAM, replacing the ideal zero-latency memory model.

---
 rtl/dmem_resp_pkg.sv | 24 ++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/sram_1rw_be.sv | 41 ++++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared types and helpers for the data-memory responder.
//   state_t   - responder FSM states
//   CNT_W     - wait-state counter width (WAIT_CYCLES legal range 0..7)
//   lane_mask - expands a 4-bit byte select into a 32-bit bit mask
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W = 3;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: M-stage SRAM-style data bus between core and responder.
//   memreadM/memwriteM - request kind
//   aluoutM            - byte address
//   writedataM/selectM - lane-aligned write data and byte enables
//   readdataM          - read word, valid in DONE
//   mem_stall          - pipeline hold while an access is in flight
//   addr_err           - one-cycle error pulse in DONE
interface dmem_responder_if;
    logic        memreadM;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [3:0]  selectM;
    logic [31:0] readdataM;
    logic        mem_stall;
    logic        addr_err;

    modport master (
        output memreadM, memwriteM, aluoutM, writedataM, selectM,
        input  readdataM, mem_stall, addr_err
    );

    modport slave (
        input  memreadM, memwriteM, aluoutM, writedataM, selectM,
        output readdataM, mem_stall, addr_err
    );
endinterface

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: single-port synchronous RAM, 2^ADDR_W x 32, byte write enables.
//   i_clk   - clock
//   i_en    - access enable
//   i_we    - write (1) / read (0)
//   i_be    - byte enables for writes
//   i_addr  - word address
//   i_wdata - write data
//   o_rdata - registered read data; holds until the next read
// No reset: contents and read register survive reset.
module sram_1rw_be
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_q;
    logic [31:0] w_mask;

    assign w_mask  = lane_mask(i_be);
    assign o_rdata = r_q;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core's M-stage data interface. Latches a
// request in IDLE, waits WAIT_CYCLES, performs one RAM cycle in ACCESS and
// releases the stall in DONE.
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-low reset
//   if_bus - dmem_responder_if slave modport (request in, read data/stall/error out)
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    dmem_responder_if.slave   if_bus
);

    localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_sel;
    logic                r_wr;
    logic                r_oor;
    logic                r_err;
    logic                r_zero;   // last completed read was out of range (or none since reset)

    logic                w_req;
    logic                w_oor;
    logic                w_ram_en;
    logic [31:0]         w_ram_q;

    assign w_req = if_bus.memreadM | if_bus.memwriteM;
    assign w_oor = (if_bus.aluoutM[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (r_cnt == '0) w_next = ACCESS;
            ACCESS:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs: only IDLE looks at the live request; elsewhere all from registers.
    always_comb begin
        if_bus.mem_stall = 1'b0;
        if_bus.addr_err  = 1'b0;
        case (r_state)
            IDLE:    if_bus.mem_stall = w_req;
            WAIT,
            ACCESS:  if_bus.mem_stall = 1'b1;
            DONE:    if_bus.addr_err  = r_err;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_wr    <= 1'b0;
            r_oor   <= 1'b0;
            r_err   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_addr  <= if_bus.aluoutM[ADDR_W+1:2];
                r_wdata <= if_bus.writedataM;
                r_sel   <= if_bus.selectM;
                // read+write together is executed as a write but still flagged
                r_wr    <= if_bus.memwriteM;
                r_oor   <= w_oor;
                r_err   <= w_oor | (if_bus.memreadM & if_bus.memwriteM);
                r_cnt   <= CNT_W'(WAIT_LOAD);
            end
            if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (r_state == ACCESS && !r_wr) begin
                r_zero <= r_oor;
            end
        end
    end

    // Out-of-range accesses never touch the RAM; the read register keeps its
    // old word and r_zero masks it to 0 instead.
    assign w_ram_en = (r_state == ACCESS) && !r_oor;

    sram_1rw_be #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (w_ram_en),
        .i_we    (r_wr),
        .i_be    (r_sel),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    assign if_bus.readdataM = r_zero ? 32'h0 : w_ram_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .if_bus(bus0)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .if_bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int b, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (b == 0) begin
            bus0.memreadM = rd; bus0.memwriteM = wr;
            bus0.aluoutM = a;   bus0.writedataM = d; bus0.selectM = s;
        end else begin
            bus1.memreadM = rd; bus1.memwriteM = wr;
            bus1.aluoutM = a;   bus1.writedataM = d; bus1.selectM = s;
        end
    endtask

    // One access: drive in a fresh cycle, hold the request until DONE,
    // then observe the following idle cycle with the request dropped.
    task automatic acc(input int b, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output int ncyc, output logic [31:0] rdata, output logic err,
                       output logic err_nx, output logic stall_nx);
        logic stall;
        bit   done;
        ncyc = 0;
        done = 0;
        @(negedge clk);
        drive(b, rd, wr, a, d, s);
        #1;
        for (int k = 0; k < 20; k++) begin
            stall = (b == 0) ? bus0.mem_stall : bus1.mem_stall;
            if (stall) ncyc++;
            else begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (!done) chk("timeout", 32'(ncyc), 32'hFFFF_FFFF);
        rdata = (b == 0) ? bus0.readdataM : bus1.readdataM;
        err   = (b == 0) ? bus0.addr_err  : bus1.addr_err;
        drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        err_nx   = (b == 0) ? bus0.addr_err  : bus1.addr_err;
        stall_nx = (b == 0) ? bus0.mem_stall : bus1.mem_stall;
    endtask

    int          nc;
    logic [31:0] rd_v;
    logic        er, er_nx, st_nx;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        chk("rst_stall0", 32'(bus0.mem_stall), 32'h0);
        chk("rst_err0",   32'(bus0.addr_err),  32'h0);
        chk("rst_rdata0", bus0.readdataM,      32'h0);
        chk("rst_stall1", 32'(bus1.mem_stall), 32'h0);
        chk("rst_rdata1", bus1.readdataM,      32'h0);
        rst = 1'b1;

        // full-word write then read
        acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, nc, rd_v, er, er_nx, st_nx);
        chk("wr_cycles", 32'(nc), 32'd4);
        chk("wr_err",    32'(er), 32'h0);
        chk("wr_rdhold", rd_v,    32'h0);
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("rd_cycles", 32'(nc), 32'd4);
        chk("rd_data",   rd_v,    32'hDEADBEEF);
        chk("rd_err",    32'(er), 32'h0);
        chk("rd_idle",   32'(st_nx), 32'h0);

        // byte / half-word merges
        acc(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'hF, nc, rd_v, er, er_nx, st_nx);
        acc(0, 1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, nc, rd_v, er, er_nx, st_nx);
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("byte_merge", rd_v, 32'h1122AA44);
        acc(0, 1'b0, 1'b1, 32'h10, 32'hBBBB0000, 4'b1100, nc, rd_v, er, er_nx, st_nx);
        chk("wr_keeps_rdata", rd_v, 32'h1122AA44);
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("half_merge", rd_v, 32'hBBBBAA44);

        // select 0 write is a no-op
        acc(0, 1'b0, 1'b1, 32'h10, 32'h12345678, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("sel0_err", 32'(er), 32'h0);
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("sel0_data", rd_v, 32'hBBBBAA44);

        // out of range: word 0 would be the aliased index
        acc(0, 1'b0, 1'b1, 32'h0, 32'hCAFE0000, 4'hF, nc, rd_v, er, er_nx, st_nx);
        acc(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("oor_rd_cycles", 32'(nc), 32'd4);
        chk("oor_rd_data",   rd_v,    32'h0);
        chk("oor_rd_err",    32'(er), 32'h1);
        chk("oor_rd_pulse",  32'(er_nx), 32'h0);
        acc(0, 1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF, nc, rd_v, er, er_nx, st_nx);
        chk("oor_wr_err", 32'(er), 32'h1);
        acc(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("oor_wr_untouched", rd_v, 32'hCAFE0000);
        chk("oor_wr_then_err", 32'(er), 32'h0);

        // read and write together: executed as write, flagged
        acc(0, 1'b1, 1'b1, 32'h20, 32'h5, 4'hF, nc, rd_v, er, er_nx, st_nx);
        chk("rw_err",   32'(er), 32'h1);
        chk("rw_pulse", 32'(er_nx), 32'h0);
        acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("rw_data", rd_v, 32'h5);

        // zero wait states, back-to-back reads
        acc(1, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, nc, rd_v, er, er_nx, st_nx);
        acc(1, 1'b0, 1'b1, 32'h44, 32'h5A5A5A5A, 4'hF, nc, rd_v, er, er_nx, st_nx);
        acc(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("w0_rd1_cycles", 32'(nc), 32'd2);
        chk("w0_rd1_data",   rd_v,    32'hA5A5A5A5);
        chk("w0_idle_stall", 32'(st_nx), 32'h0);
        acc(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("w0_rd2_cycles", 32'(nc), 32'd2);
        chk("w0_rd2_data",   rd_v,    32'h5A5A5A5A);

        // async reset during WAIT of a write
        acc(0, 1'b0, 1'b1, 32'h30, 32'h7, 4'hF, nc, rd_v, er, er_nx, st_nx);
        acc(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("pre_rst_data", rd_v, 32'h7);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        #2;
        chk("in_wait_stall", 32'(bus0.mem_stall), 32'h1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(bus0.mem_stall), 32'h0);
        chk("mid_rst_err",   32'(bus0.addr_err),  32'h0);
        chk("mid_rst_rdata", bus0.readdataM,      32'h0);
        @(negedge clk);
        rst = 1'b1;
        acc(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, nc, rd_v, er, er_nx, st_nx);
        chk("post_rst_data", rd_v, 32'h7);
        chk("post_rst_cycles", 32'(nc), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
